// File: rtl/mod5_stream_sched_pkg.sv
// Shared types and arithmetic helpers for the serial residue scheduler.
package mod5_stream_sched_pkg;

  // Scheduler phases: wait for a request, stream the word, present the result.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } sched_state_e;

  // One MSB-first step of the residue recurrence: (2r + b) mod divisor.
  // With r < divisor, 2r + b < 2*divisor, so one conditional subtract is exact
  // for any divisor, not only powers of two.
  function automatic logic [31:0] residue_step(input logic [31:0] r,
                                               input logic        b,
                                               input logic [31:0] divisor);
    logic [31:0] t;
    t = {r[30:0], b};
    if (t >= divisor) begin
      return t - divisor;
    end else begin
      return t;
    end
  endfunction

endpackage

// File: rtl/mod5_stream_sched_rr_arbiter.sv
// Combinational round-robin arbiter: searches from last_id+1 upward, wrapping,
// and grants the first asserted request. Grant vector is one-hot or zero.
module rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int IDW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDW-1:0]     last_id_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDW-1:0]     gnt_idx_o
);

  logic [31:0] idx_s;
  logic        found_s;

  // Rotating priority search; the first hit after last_id wins.
  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    found_s   = 1'b0;
    idx_s     = 32'd0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx_s = (32'(last_id_i) + 32'(k)) % 32'(NUM_REQ);
      if (!found_s && req_i[idx_s[IDW-1:0]]) begin
        found_s                 = 1'b1;
        gnt_o[idx_s[IDW-1:0]]   = 1'b1;
        gnt_idx_o               = idx_s[IDW-1:0];
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/mod5_stream_sched.sv
// Shares one serial (2r+b) mod DIVISOR engine among NUM_REQ requesters.
// One word in flight at a time; results are returned in grant order.
module mod5_stream_sched
  import mod5_stream_sched_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  parameter  int WIDTH   = 8,
  parameter  int DIVISOR = 5,
  localparam int IDW     = $clog2(NUM_REQ),
  localparam int RW      = $clog2(DIVISOR),
  localparam int CW      = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [IDW-1:0]           res_id,
  output logic                     res_divisible,
  output logic [RW-1:0]            res_remainder,
  output logic                     busy
);

  sched_state_e         state_q, state_d;
  logic [WIDTH-1:0]     shreg_q, shreg_d;
  logic [RW-1:0]        residue_q, residue_d;
  logic [CW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [IDW-1:0]       cur_id_q, cur_id_d;
  logic [IDW-1:0]       last_id_q, last_id_d;
  logic                 res_valid_q, res_valid_d;
  logic [IDW-1:0]       res_id_q, res_id_d;
  logic                 res_div_q, res_div_d;
  logic [RW-1:0]        res_rem_q, res_rem_d;

  logic [NUM_REQ-1:0]   gnt_s;
  logic [IDW-1:0]       gnt_idx_s;
  logic [31:0]          step_full_s;
  logic [RW-1:0]        step_s;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req_i     (req_valid),
    .last_id_i (last_id_q),
    .gnt_o     (gnt_s),
    .gnt_idx_o (gnt_idx_s)
  );

  assign step_full_s = residue_step(32'(residue_q), shreg_q[WIDTH-1], 32'(DIVISOR));
  assign step_s      = step_full_s[RW-1:0];

  // Grants are offered only while idle and out of reset.
  always_comb begin
    if ((state_q == IDLE) && !rst) begin
      req_ready = gnt_s;
    end else begin
      req_ready = '0;
    end
  end

  // Next-state logic: capture, stream MSB-first, then hold result until taken.
  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    residue_d   = residue_q;
    bit_cnt_d   = bit_cnt_q;
    cur_id_d    = cur_id_q;
    last_id_d   = last_id_q;
    res_valid_d = res_valid_q;
    res_id_d    = res_id_q;
    res_div_d   = res_div_q;
    res_rem_d   = res_rem_q;
    case (state_q)
      IDLE: begin
        if (|gnt_s) begin
          shreg_d   = req_data[gnt_idx_s*WIDTH +: WIDTH];
          residue_d = '0;
          bit_cnt_d = CW'(WIDTH - 1);
          cur_id_d  = gnt_idx_s;
          state_d   = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        residue_d = step_s;
        shreg_d   = shreg_q << 1;
        if (bit_cnt_q == '0) begin
          state_d     = DONE;
          res_valid_d = 1'b1;
          res_id_d    = cur_id_q;
          res_rem_d   = step_s;
          res_div_d   = (step_s == '0);
        end else begin
          bit_cnt_d = bit_cnt_q - CW'(1);
        end
      end
      DONE: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          last_id_d   = cur_id_q;
          state_d     = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d     = IDLE;
        res_valid_d = 1'b0;
      end
    endcase
  end

  // State and result registers; reset drops any in-flight word.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      residue_q   <= '0;
      bit_cnt_q   <= '0;
      cur_id_q    <= '0;
      last_id_q   <= IDW'(NUM_REQ - 1);
      res_valid_q <= 1'b0;
      res_id_q    <= '0;
      res_div_q   <= 1'b0;
      res_rem_q   <= '0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      residue_q   <= residue_d;
      bit_cnt_q   <= bit_cnt_d;
      cur_id_q    <= cur_id_d;
      last_id_q   <= last_id_d;
      res_valid_q <= res_valid_d;
      res_id_q    <= res_id_d;
      res_div_q   <= res_div_d;
      res_rem_q   <= res_rem_d;
    end
  end

  assign res_valid     = res_valid_q;
  assign res_id        = res_id_q;
  assign res_divisible = res_div_q;
  assign res_remainder = res_rem_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_mod5_stream_sched.sv
// Directed bench for mod5_stream_sched with a result scoreboard.
module tb_mod5_stream_sched;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        res_valid;
  logic        res_ready;
  logic [1:0]  res_id;
  logic        res_divisible;
  logic [2:0]  res_remainder;
  logic        busy;

  logic [3:0]  r3_valid;
  logic [31:0] r3_data;
  logic [3:0]  r3_ready;
  logic        r3_res_valid;
  logic [1:0]  r3_res_id;
  logic        r3_res_div;
  logic [1:0]  r3_res_rem;
  logic        r3_busy;

  typedef struct {
    int   id;
    int   rem;
    logic div;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] words [4];
  int         checks;
  int         failures;

  mod5_stream_sched #(.NUM_REQ(4), .WIDTH(8), .DIVISOR(5)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .res_valid(res_valid), .res_ready(res_ready),
    .res_id(res_id), .res_divisible(res_divisible), .res_remainder(res_remainder),
    .busy(busy)
  );

  mod5_stream_sched #(.NUM_REQ(4), .WIDTH(8), .DIVISOR(3)) dut3 (
    .clk(clk), .rst(rst), .req_valid(r3_valid), .req_data(r3_data),
    .req_ready(r3_ready), .res_valid(r3_res_valid), .res_ready(1'b1),
    .res_id(r3_res_id), .res_divisible(r3_res_div), .res_remainder(r3_res_rem),
    .busy(r3_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_data();
    req_data = {words[3], words[2], words[1], words[0]};
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Present requests, expect grant g, push expectation, complete the handshake.
  task automatic grant_one(input logic [3:0] valid, input int g, input bit push, input bit hold);
    exp_t e;
    req_valid = valid;
    #1;
    chk("req_ready_grant", 32'(req_ready), 32'(4'b0001 << g));
    if (push) begin
      e.id  = g;
      e.rem = int'(words[g]) % 5;
      e.div = ((int'(words[g]) % 5) == 0);
      sb.push_back(e);
    end
    @(negedge clk);
    if (!hold) req_valid = 4'b0000;
    chk("busy_shift", 32'(busy), 32'd1);
    chk("req_ready_shift", 32'(req_ready), 32'd0);
  endtask

  // Wait for res_valid, check latency, compare against scoreboard head.
  task automatic await_result(input int exp_lat);
    int   cnt;
    exp_t e;
    cnt = 0;
    while (res_valid !== 1'b1 && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    chk("latency", 32'(cnt), 32'(exp_lat));
    chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("res_id", 32'(res_id), 32'(e.id));
      chk("res_remainder", 32'(res_remainder), 32'(e.rem));
      chk("res_divisible", 32'(res_divisible), 32'(e.div));
    end
  endtask

  // With res_ready high on DONE entry the result lasts one cycle.
  task automatic post_accept();
    @(negedge clk);
    chk("res_valid_single", 32'(res_valid), 32'd0);
    chk("busy_idle", 32'(busy), 32'd0);
  endtask

  task automatic d3_run(input logic [7:0] w);
    int cnt;
    r3_data = {24'd0, w};
    r3_valid = 4'b0001;
    #1;
    chk("d3_req_ready", 32'(r3_ready), 32'd1);
    @(negedge clk);
    r3_valid = 4'b0000;
    cnt = 0;
    while (r3_res_valid !== 1'b1 && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    chk("d3_latency", 32'(cnt), 32'd8);
    chk("d3_rem", 32'(r3_res_rem), 32'(int'(w) % 3));
    chk("d3_div", 32'(r3_res_div), 32'((int'(w) % 3) == 0));
    chk("d3_id", 32'(r3_res_id), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    int p;
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    req_valid = 4'b0000;
    res_ready = 1'b1;
    r3_valid  = 4'b0000;
    r3_data   = 32'd0;
    for (int i = 0; i < 4; i++) words[i] = 8'd0;
    words[0] = 8'd25;
    set_data();

    // 1: reset state, then first grant goes to req0
    req_valid = 4'b0001;
    @(negedge clk);
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_id", 32'(res_id), 32'd0);
    chk("rst_res_rem", 32'(res_remainder), 32'd0);
    chk("rst_res_div", 32'(res_divisible), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    grant_one(4'b0001, 0, 1'b1, 1'b0);
    await_result(8);
    post_accept();

    // 2: req1 alone, word 7 -> rem 2
    words[1] = 8'd7;
    set_data();
    grant_one(4'b0010, 1, 1'b1, 1'b0);
    await_result(8);
    post_accept();

    // 3: all valid with 10..13 held -> 0,1,2,3 then 0 again
    do_reset();
    for (int i = 0; i < 4; i++) words[i] = 8'(10 + i);
    set_data();
    for (int g = 0; g < 4; g++) begin
      grant_one(4'b1111, g, 1'b1, 1'b1);
      await_result(8);
      post_accept();
    end
    grant_one(4'b1111, 0, 1'b1, 1'b0);
    await_result(8);
    post_accept();

    // 4: consumer stalls in DONE; outputs hold and no grants are offered
    res_ready = 1'b0;
    grant_one(4'b0100, 2, 1'b1, 1'b0);
    await_result(8);
    req_valid = 4'b1011;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_valid", 32'(res_valid), 32'd1);
      chk("stall_id", 32'(res_id), 32'd2);
      chk("stall_rem", 32'(res_remainder), 32'd2);
      chk("stall_div", 32'(res_divisible), 32'd0);
      chk("stall_req_ready", 32'(req_ready), 32'd0);
    end
    res_ready = 1'b1;
    @(negedge clk);
    chk("stall_release_valid", 32'(res_valid), 32'd0);
    chk("stall_release_busy", 32'(busy), 32'd0);
    chk("stall_release_grant", 32'(req_ready), 32'b1000);
    grant_one(4'b1011, 3, 1'b1, 1'b0);
    await_result(8);
    post_accept();

    // 5: reset during SHIFT drops the word; req0 regains priority
    grant_one(4'b0010, 1, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    req_valid = 4'b0011;
    @(negedge clk);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_res_valid", 32'(res_valid), 32'd0);
    chk("midrst_req_ready", 32'(req_ready), 32'd0);
    rst = 1'b0;
    grant_one(4'b0011, 0, 1'b1, 1'b0);
    await_result(8);
    post_accept();

    // 6: 255 and 0 are both divisible by 5
    words[0] = 8'd255;
    set_data();
    grant_one(4'b0001, 0, 1'b1, 1'b0);
    await_result(8);
    post_accept();
    words[0] = 8'd0;
    set_data();
    grant_one(4'b0001, 0, 1'b1, 1'b0);
    await_result(8);
    post_accept();

    // Random words on a single requester at a time
    for (int i = 0; i < 8; i++) begin
      p = int'($urandom_range(3));
      words[p] = 8'($urandom_range(255));
      set_data();
      grant_one(4'b0001 << p, p, 1'b1, 1'b0);
      await_result(8);
      post_accept();
    end

    // DIVISOR=3 instance: 7 -> 1, 9 -> 0
    d3_run(8'd7);
    d3_run(8'd9);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
